// File: rtl/sram_track_buf_if.sv
// Host and stream port bundle for sram_track_buf.
// master drives requests; slave (the buffer) returns data and stream status.
interface sram_track_buf_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
);
  logic              a_en;
  logic              a_rw;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_din;
  logic [DATA_W-1:0] a_dout;
  logic              a_valid;
  logic              s_start;
  logic              s_stop;
  logic              s_rw;
  logic              s_step;
  logic [DATA_W-1:0] s_din;
  logic [DATA_W-1:0] s_dout;
  logic              s_valid;
  logic              s_busy;
  logic              s_index;
  logic [ADDR_W-1:0] s_ptr;

  modport master (
    output a_en, a_rw, a_addr, a_din, s_start, s_stop, s_rw, s_step, s_din,
    input  a_dout, a_valid, s_dout, s_valid, s_busy, s_index, s_ptr
  );
  modport slave (
    input  a_en, a_rw, a_addr, a_din, s_start, s_stop, s_rw, s_step, s_din,
    output a_dout, a_valid, s_dout, s_valid, s_busy, s_index, s_ptr
  );
endinterface

// File: rtl/sram_track_buf.sv
// Dual-port track buffer: random-access host port plus a wrapping sequential stream port.
// Define SRAM_TRACK_BUF_WR_FWD_EN to forward same-cycle cross-port writes into reads.
module sram_track_buf #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 13,
  parameter int TRACK_LEN = 6250
) (
  input logic           clk,
  input logic           rst,
  sram_track_buf_if.slave bus
);
  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TRACK_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic              mode;  // 1 = read stream
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] a_dout, s_dout;
  logic              a_valid, s_valid, busy, index;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              h_we, h_re, s_act, s_we;
  logic [DATA_W-1:0] a_rd_data, s_rd_data;

  // Start and stop both suppress the stream access for the cycle they arrive in.
  always_comb begin
    h_we  = !rst && bus.a_en && !bus.a_rw;
    h_re  = !rst && bus.a_en &&  bus.a_rw;
    s_act = !rst && (state == RUN) && bus.s_step && !bus.s_stop && !bus.s_start;
    s_we  = s_act && !mode;
  end

`ifdef SRAM_TRACK_BUF_WR_FWD_EN
  always_comb begin
    a_rd_data = (s_we && (ptr == bus.a_addr)) ? bus.s_din : mem[bus.a_addr];
    s_rd_data = (h_we && (bus.a_addr == ptr)) ? bus.a_din : mem[ptr];
  end
`else
  always_comb begin
    a_rd_data = mem[bus.a_addr];
    s_rd_data = mem[ptr];
  end
`endif

  // Host write is ordered last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (s_we) mem[ptr] <= bus.s_din;
    if (h_we) mem[bus.a_addr] <= bus.a_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_dout  <= '0;
      a_valid <= 1'b0;
    end else begin
      a_valid <= h_re;
      if (h_re) a_dout <= a_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mode    <= 1'b0;
      ptr     <= '0;
      s_dout  <= '0;
      s_valid <= 1'b0;
      busy    <= 1'b0;
      index   <= 1'b0;
    end else begin
      s_valid <= 1'b0;
      index   <= 1'b0;
      unique case (state)
        IDLE: if (bus.s_start) begin
          state <= RUN;
          busy  <= 1'b1;
          mode  <= bus.s_rw;
          ptr   <= '0;
        end
        RUN: begin
          if (bus.s_stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bus.s_start) begin
            mode <= bus.s_rw;
            ptr  <= '0;
          end else if (bus.s_step) begin
            if (mode) begin
              s_dout  <= s_rd_data;
              s_valid <= 1'b1;
            end
            if (ptr == LAST) begin
              ptr   <= '0;
              index <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.a_dout  = a_dout;
  assign bus.a_valid = a_valid;
  assign bus.s_dout  = s_dout;
  assign bus.s_valid = s_valid;
  assign bus.s_busy  = busy;
  assign bus.s_index = index;
  assign bus.s_ptr   = ptr;
endmodule

// File: tb/tb_sram_track_buf.sv
// Self-checking bench for sram_track_buf with a short track (TRACK_LEN=4).
module tb_sram_track_buf;
  localparam int DW = 8, AW = 4, TL = 4;
`ifdef SRAM_TRACK_BUF_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_track_buf_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  sram_track_buf #(.DATA_W(DW), .ADDR_W(AW), .TRACK_LEN(TL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0, failures = 0, idx_cnt = 0;
  logic [DW-1:0] aq[$], sq[$];

  typedef struct {
    logic          en;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } hvec_t;
  hvec_t hv[10];
  logic [DW-1:0] wd[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.a_en = 1'b0; bus.s_start = 1'b0; bus.s_stop = 1'b0; bus.s_step = 1'b0;
  endtask

  task automatic host(input logic en, input logic rw, input logic [AW-1:0] addr,
                      input logic [DW-1:0] din, input logic [DW-1:0] exp);
    bus.a_en = en; bus.a_rw = rw; bus.a_addr = addr; bus.a_din = din;
    if (en && rw) aq.push_back(exp);
  endtask

  task automatic sstep(input logic [DW-1:0] din);
    bus.s_step = 1'b1; bus.s_din = din;
  endtask

  // One clock: outputs are sampled just after the edge and matched against the queues.
  task automatic cyc();
    @(posedge clk); #1;
    if (aq.size() > 0) begin
      chk("a_valid", bus.a_valid, 1);
      chk("a_dout", bus.a_dout, aq.pop_front());
    end else chk("a_valid_idle", bus.a_valid, 0);
    if (sq.size() > 0) begin
      chk("s_valid", bus.s_valid, 1);
      chk("s_dout", bus.s_dout, sq.pop_front());
    end else chk("s_valid_idle", bus.s_valid, 0);
    if (bus.s_index) idx_cnt++;
    idle_in();
  endtask

  initial begin
    hv[0] = '{1'b1, 1'b0, 4'd0, 8'hFF, 8'h00};
    hv[1] = '{1'b1, 1'b0, 4'd1, 8'hAA, 8'h00};
    hv[2] = '{1'b1, 1'b1, 4'd0, 8'h00, 8'hFF};
    hv[3] = '{1'b1, 1'b1, 4'd1, 8'h00, 8'hAA};
    hv[4] = '{1'b0, 1'b1, 4'd1, 8'h00, 8'h00};
    hv[5] = '{1'b1, 1'b0, 4'd5, 8'h3C, 8'h00};
    hv[6] = '{1'b1, 1'b1, 4'd5, 8'h00, 8'h3C};
    hv[7] = '{1'b1, 1'b0, 4'd5, 8'h00, 8'h00};
    hv[8] = '{1'b1, 1'b1, 4'd5, 8'h00, 8'h00};
    hv[9] = '{1'b1, 1'b1, 4'd0, 8'h00, 8'hFF};
    wd = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst = 1'b1; idle_in();
    bus.a_rw = 1'b0; bus.a_addr = '0; bus.a_din = '0; bus.s_rw = 1'b0; bus.s_din = '0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_a_dout", bus.a_dout, 0);
    chk("rst_s_dout", bus.s_dout, 0);
    chk("rst_s_busy", bus.s_busy, 0);
    chk("rst_s_index", bus.s_index, 0);
    chk("rst_s_ptr", bus.s_ptr, 0);

    // Host port vectors
    for (int i = 0; i < 10; i++) begin
      host(hv[i].en, hv[i].rw, hv[i].addr, hv[i].din, hv[i].exp);
      cyc();
    end
    cyc();
    chk("a_dout_hold", bus.a_dout, 8'hFF);

    // Write stream with wrap
    bus.s_start = 1'b1; bus.s_rw = 1'b0;
    cyc();
    chk("wr_start_busy", bus.s_busy, 1);
    chk("wr_start_ptr", bus.s_ptr, 0);
    for (int i = 0; i < 4; i++) begin
      sstep(wd[i]);
      cyc();
      chk("wr_ptr", bus.s_ptr, (i + 1) % TL);
      chk("wr_index", bus.s_index, (i == 3) ? 1 : 0);
    end
    cyc();
    chk("wr_index_one_cycle", bus.s_index, 0);
    bus.s_stop = 1'b1;
    cyc();
    chk("wr_stop_busy", bus.s_busy, 0);
    for (int i = 0; i < 4; i++) begin
      host(1'b1, 1'b1, AW'(i), 8'h00, wd[i]);
      cyc();
    end

    // Read stream, 5 steps across the wrap
    bus.s_start = 1'b1; bus.s_rw = 1'b1;
    cyc();
    idx_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      sstep(8'h00); sq.push_back(wd[i % 4]);
      cyc();
    end
    chk("rd_index_count", idx_cnt, 1);
    chk("rd_ptr", bus.s_ptr, 1);

    // Cross-port collisions
    sstep(8'h00); sq.push_back(8'h22);
    cyc();
    host(1'b1, 1'b0, 4'd2, 8'h5A, 8'h00);
    sstep(8'h00); sq.push_back(FWD ? 8'h5A : 8'h33);
    cyc();
    host(1'b1, 1'b1, 4'd2, 8'h00, 8'h5A);
    cyc();
    bus.s_start = 1'b1; bus.s_rw = 1'b0;
    cyc();
    chk("restart_ptr", bus.s_ptr, 0);
    host(1'b1, 1'b0, 4'd0, 8'h77, 8'h00);
    sstep(8'h99);
    cyc();
    host(1'b1, 1'b1, 4'd1, 8'h00, FWD ? 8'h66 : 8'h22);
    sstep(8'h66);
    cyc();
    chk("coll_ptr", bus.s_ptr, 2);
    host(1'b1, 1'b1, 4'd0, 8'h00, 8'h77);
    cyc();
    host(1'b1, 1'b1, 4'd1, 8'h00, 8'h66);
    cyc();

    // Reset mid write stream at ptr=2 with step and host write pending
    host(1'b1, 1'b0, 4'd9, 8'h12, 8'h00);
    cyc();
    rst = 1'b1;
    sstep(8'hEE); bus.s_start = 1'b1;
    host(1'b1, 1'b0, 4'd9, 8'hC3, 8'h00);
    cyc();
    rst = 1'b0;
    chk("mid_rst_busy", bus.s_busy, 0);
    chk("mid_rst_ptr", bus.s_ptr, 0);
    host(1'b1, 1'b1, 4'd2, 8'h00, 8'h5A);
    cyc();
    host(1'b1, 1'b1, 4'd9, 8'h00, 8'h12);
    cyc();

    // Stop beats step; step in IDLE ignored
    bus.s_start = 1'b1; bus.s_rw = 1'b0;
    cyc();
    sstep(8'hD0);
    cyc();
    bus.s_stop = 1'b1; sstep(8'hBB);
    cyc();
    chk("stop_busy", bus.s_busy, 0);
    sstep(8'hCC);
    cyc();
    chk("idle_step_busy", bus.s_busy, 0);
    host(1'b1, 1'b1, 4'd1, 8'h00, 8'h66);
    cyc();
    host(1'b1, 1'b1, 4'd0, 8'h00, 8'hD0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_track_buf.md
SRAM_TRACK_BUF -- requirements
Module: sram_track_buf

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits.
REQ-002 Parameter ADDR_W, default 13, address width; memory depth is 2**ADDR_W words.
REQ-003 Parameter TRACK_LEN, default 6250, stream wrap length in words; legal range 2..2**ADDR_W.
REQ-004 clk  in  1  single clock; all logic is on the rising edge; reset is synchronous and active-high.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 a_en  in  1  host port access strobe.
REQ-007 a_rw  in  1  host direction: 1 = read, 0 = write.
REQ-008 a_addr  in  ADDR_W  host word address.
REQ-009 a_din  in  DATA_W  host write data.
REQ-010 a_dout  out  DATA_W  host read data.
REQ-011 a_valid  out  1  a_dout is valid this cycle.
REQ-012 s_start  in  1  stream start pulse.
REQ-013 s_stop  in  1  stream stop pulse.
REQ-014 s_rw  in  1  stream mode, sampled at start: 1 = read stream, 0 = write stream.
REQ-015 s_step  in  1  advance one word.
REQ-016 s_din  in  DATA_W  stream write data.
REQ-017 s_dout  out  DATA_W  stream read data.
REQ-018 s_valid  out  1  s_dout is valid this cycle.
REQ-019 s_busy  out  1  stream FSM is in RUN.
REQ-020 s_index  out  1  one-cycle pulse on pointer wrap.
REQ-021 s_ptr  out  ADDR_W  current stream pointer.

Function
REQ-022 Memory SHALL be true dual-port: host port and stream port are each served every cycle, with no arbitration stall.
REQ-023 Host write: a_en=1, a_rw=0 SHALL store a_din at a_addr on that edge; a_valid stays 0.
REQ-024 Host read: a_en=1, a_rw=1 SHALL present mem[a_addr] on a_dout with a_valid=1 exactly one cycle later; a_dout holds its value until the next read.
REQ-025 a_en=0 SHALL perform no access; a_valid=0 the following cycle.
REQ-026 Stream FSM SHALL have states IDLE and RUN; IDLE -> RUN on s_start, latching s_rw and clearing s_ptr to 0.
REQ-027 RUN -> IDLE on s_stop; s_stop takes priority over s_step in the same cycle, so no access occurs in that cycle.
REQ-028 s_start while in RUN SHALL restart: s_ptr cleared to 0, mode re-latched, no access that cycle.
REQ-029 In RUN, s_step in write mode SHALL store s_din at mem[s_ptr] and increment s_ptr.
REQ-030 In RUN, s_step in read mode SHALL present mem[s_ptr] on s_dout with s_valid=1 one cycle later, then increment s_ptr.
REQ-031 At s_ptr = TRACK_LEN-1, s_step SHALL wrap s_ptr to 0 and pulse s_index for exactly one cycle, coincident with the pointer update.
REQ-032 s_step in IDLE SHALL be ignored.
REQ-033 If both ports write the same address in one cycle, the host write SHALL win.

Reset
REQ-034 On rst: FSM -> IDLE; s_ptr=0; a_dout=0; s_dout=0; a_valid=0; s_valid=0; s_busy=0; s_index=0.
REQ-035 Reset SHALL abort a running stream mid-operation, with no write performed in the reset cycle; memory contents are not cleared.
REQ-036 rst SHALL override s_start, s_step and a_en asserted in the same cycle.

Configuration
REQ-037 Macro SRAM_TRACK_BUF_WR_FWD_EN defined: a read on one port to an address written by the other port in the same cycle SHALL return the new data.
REQ-038 Macro undefined: such a read SHALL return the old data (read-before-write); no forwarding logic is built.

Verification
REQ-039 Host write 8'hFF @0, 8'hAA @1; then read @0, @1 -> a_dout=FF then AA, each one cycle after its request, a_valid=1.
REQ-040 TRACK_LEN=4: start write stream, 4 steps with data 11,22,33,44 -> mem[0..3]=11..44; s_index pulses on 4th step; s_ptr=0 afterwards.
REQ-041 Read stream over the same data, 5 steps -> s_dout=11,22,33,44,11; s_index pulses once.
REQ-042 Host write 8'h5A @2 while stream reads @2 -> s_dout=5A with macro defined, old value without it; same-address dual write leaves host data.
REQ-043 rst mid-write-stream (s_ptr=2, s_step=1) -> s_busy=0, s_ptr=0, mem[2] unchanged; s_stop with s_step -> no access, IDLE.
